// File: rtl/morse_pkg.sv
// Shared Morse definitions: decoder FSM state encoding and the ten digit
// patterns. Patterns are five symbols wide, first symbol in the MSB,
// 1 = dash, 0 = dot. The display/encoder path uses the same constants.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2,
        ST_EMIT  = 2'd3
    } morse_state_e;

    localparam int SYM_MAX = 5;

    localparam logic [4:0] MORSE_0 = 5'b11111;
    localparam logic [4:0] MORSE_1 = 5'b01111;
    localparam logic [4:0] MORSE_2 = 5'b00111;
    localparam logic [4:0] MORSE_3 = 5'b00011;
    localparam logic [4:0] MORSE_4 = 5'b00001;
    localparam logic [4:0] MORSE_5 = 5'b00000;
    localparam logic [4:0] MORSE_6 = 5'b10000;
    localparam logic [4:0] MORSE_7 = 5'b11000;
    localparam logic [4:0] MORSE_8 = 5'b11100;
    localparam logic [4:0] MORSE_9 = 5'b11110;

    typedef struct packed {
        logic       valid;
        logic [3:0] digit;
    } morse_digit_t;

    // Map a complete 5-symbol pattern to its digit; valid=0 for any other code.
    function automatic morse_digit_t morse_decode(input logic [4:0] pat);
        morse_digit_t r;
        r.valid = 1'b1;
        r.digit = 4'd0;
        case (pat)
            MORSE_0: r.digit = 4'd0;
            MORSE_1: r.digit = 4'd1;
            MORSE_2: r.digit = 4'd2;
            MORSE_3: r.digit = 4'd3;
            MORSE_4: r.digit = 4'd4;
            MORSE_5: r.digit = 4'd5;
            MORSE_6: r.digit = 4'd6;
            MORSE_7: r.digit = 4'd7;
            MORSE_8: r.digit = 4'd8;
            MORSE_9: r.digit = 4'd9;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_input_decoder_key_sync.sv
// Brings the asynchronous Morse key into the clk domain through two flops
// and derives single-cycle rise/fall pulses against a one-cycle delayed copy.
module morse_key_sync (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic key_s_q;
    logic key_dly_q;

    // Two-stage synchronizer plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q    <= 1'b0;
            key_s_q   <= 1'b0;
            key_dly_q <= 1'b0;
        end else begin
            meta_q    <= key;
            key_s_q   <= meta_q;
            key_dly_q <= key_s_q;
        end
    end

    assign level = key_s_q;
    assign rise  = key_s_q & ~key_dly_q;
    assign fall  = ~key_s_q & key_dly_q;

endmodule

// File: rtl/morse_input_decoder.sv
// Morse key decoder: times each press as dot or dash, collects five symbols
// into a pattern and emits the decoded digit (load) or a rejection (invalid).
// A digit is abandoned if the key stays idle for GAP_CYCLES between symbols.
module morse_input_decoder
    import morse_pkg::*;
#(
    parameter int DASH_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       enable,
    output logic [3:0] user_input,
    output logic       load,
    output logic       invalid,
    output logic [2:0] symbol_count,
    output logic       busy
);

    localparam int PRESS_W = $clog2(DASH_CYCLES + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

    localparam logic [PRESS_W-1:0] DASH_LIM = PRESS_W'(DASH_CYCLES);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic key_level;
    logic key_rise;
    logic key_fall;

    morse_state_e         state_q,      state_d;
    logic [PRESS_W-1:0]   press_cnt_q,  press_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q,    gap_cnt_d;
    logic [4:0]           pattern_q,    pattern_d;
    logic [2:0]           sym_cnt_q,    sym_cnt_d;
    logic [3:0]           user_input_q, user_input_d;
    logic                 load_q,       load_d;
    logic                 invalid_q,    invalid_d;
    morse_digit_t         dec;

    morse_key_sync u_key_sync (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .level (key_level),
        .rise  (key_rise),
        .fall  (key_fall)
    );

    // Next-state logic. The press counter counts every cycle key_s is high,
    // including the rising-edge cycle, so an N-cycle press reads N.
    always_comb begin
        state_d      = state_q;
        press_cnt_d  = press_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        pattern_d    = pattern_q;
        sym_cnt_d    = sym_cnt_q;
        user_input_d = user_input_q;
        load_d       = 1'b0;
        invalid_d    = 1'b0;
        dec          = morse_decode(pattern_q);

        if (!enable) begin
            state_d     = ST_IDLE;
            press_cnt_d = '0;
            gap_cnt_d   = '0;
            pattern_d   = '0;
            sym_cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    press_cnt_d = '0;
                    gap_cnt_d   = '0;
                    if (key_rise) begin
                        state_d     = ST_PRESS;
                        press_cnt_d = PRESS_W'(1);
                    end
                end

                ST_PRESS: begin
                    if (key_fall) begin
                        pattern_d = {pattern_q[3:0], (press_cnt_q == DASH_LIM)};
                        sym_cnt_d = sym_cnt_q + 3'd1;
                        gap_cnt_d = '0;
                        if (sym_cnt_q == 3'(SYM_MAX - 1)) begin
                            state_d = ST_EMIT;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else if (key_level && (press_cnt_q != DASH_LIM)) begin
                        press_cnt_d = press_cnt_q + PRESS_W'(1);
                    end
                end

                ST_GAP: begin
                    // A new press wins over a timeout landing in the same cycle.
                    if (key_rise) begin
                        state_d     = ST_PRESS;
                        press_cnt_d = PRESS_W'(1);
                    end else if (gap_cnt_q == GAP_LAST) begin
                        invalid_d   = 1'b1;
                        state_d     = ST_IDLE;
                        pattern_d   = '0;
                        sym_cnt_d   = '0;
                        gap_cnt_d   = '0;
                        press_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                    end
                end

                ST_EMIT: begin
                    if (dec.valid) begin
                        user_input_d = dec.digit;
                        load_d       = 1'b1;
                    end else begin
                        invalid_d = 1'b1;
                    end
                    state_d     = ST_IDLE;
                    pattern_d   = '0;
                    sym_cnt_d   = '0;
                    press_cnt_d = '0;
                    gap_cnt_d   = '0;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            press_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            pattern_q    <= '0;
            sym_cnt_q    <= '0;
            user_input_q <= '0;
            load_q       <= 1'b0;
            invalid_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            press_cnt_q  <= press_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            pattern_q    <= pattern_d;
            sym_cnt_q    <= sym_cnt_d;
            user_input_q <= user_input_d;
            load_q       <= load_d;
            invalid_q    <= invalid_d;
        end
    end

    assign user_input   = user_input_q;
    assign load         = load_q;
    assign invalid      = invalid_q;
    assign symbol_count = sym_cnt_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/morse_input_decoder.md
MORSE_INPUT_DECODER -- requirements
Module: morse_input_decoder

Interface
REQ-001 Parameter DASH_CYCLES, default 25_000_000: press length in cycles at or above which a press is a dash (0.5 s at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 100_000_000: maximum idle cycles allowed between symbols of one digit (2 s).
REQ-003 clk  input  1  system clock; the block uses one clock domain only.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 key  input  1  debounced Morse key, active-high, asynchronous to clk.
REQ-006 enable  input  1  decoding allowed; driven by game control.
REQ-007 user_input  output  4  decoded digit 0-9, registered.
REQ-008 load  output  1  one-cycle strobe: user_input is valid.
REQ-009 invalid  output  1  one-cycle strobe: pattern rejected or gap timeout.
REQ-010 symbol_count  output  3  symbols captured so far for the current digit (0-5).
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 key SHALL pass through a 2-flop synchronizer (key_s); edges SHALL be detected against a 1-cycle delayed copy (key_d).
REQ-013 The FSM states SHALL be IDLE, PRESS, GAP and EMIT.
REQ-014 IDLE: on a rising edge of key_s with enable=1 -> PRESS; the press counter is cleared.
REQ-015 PRESS: the counter SHALL increment each cycle while key_s=1 and saturate at DASH_CYCLES.
REQ-016 On a falling edge in PRESS: the symbol is a dash (1) if the counter = DASH_CYCLES, else a dot (0). It is shifted in at the LSB of a 5-bit pattern, and symbol_count increments.
REQ-017 After the shift: symbol_count=5 -> EMIT; otherwise -> GAP with the gap counter cleared.
REQ-018 GAP: the gap counter increments each cycle. A rising edge before it reaches GAP_CYCLES -> PRESS. Reaching GAP_CYCLES -> invalid pulse, pattern/count cleared, -> IDLE.
REQ-019 EMIT (one cycle) SHALL decode the pattern, first symbol = MSB:
- 11111=0, 01111=1, 00111=2, 00011=3, 00001=4
- 00000=5, 10000=6, 11000=7, 11100=8, 11110=9
- Valid pattern: user_input is updated and load is pulsed.
- Any other pattern: invalid is pulsed and user_input holds its value.
Both outcomes clear the pattern and symbol_count and return to IDLE.
REQ-020 load/invalid SHALL go high at the second clk edge after the edge at which key_s is first sampled low, and SHALL last exactly one cycle.
REQ-021 load and invalid SHALL never be high in the same cycle.
REQ-022 enable=0 in any state SHALL force IDLE next cycle, clear the pattern, symbol_count and counters, and suppress load/invalid.
REQ-023 A rising key edge while enable=0 SHALL be ignored. A press already in progress when enable rises SHALL NOT be decoded; the FSM waits for the next rising edge.
REQ-024 The counters SHALL be wide enough for the parameter values (clog2) and SHALL never wrap.

Reset
REQ-025 rst=0 SHALL asynchronously force:
- state=IDLE
- user_input=0, load=0, invalid=0, symbol_count=0, busy=0
- pattern and counters to 0
- synchronizer flops to 0
REQ-026 Reset mid-digit SHALL discard partial symbols; no strobe is emitted after release.

Structure
REQ-027 The FSM state encoding and the ten digit-pattern constants SHALL live in a shared Morse package, also used by the Morse display/encoder path.
REQ-028 A single sub-module, morse_key_sync, SHALL implement the synchronizer and edge detect (outputs: level, rise, fall).
REQ-029 The block feeds the game-control stage directly: user_input -> user_input, load -> load.

Verification (bench uses DASH_CYCLES=8, GAP_CYCLES=20)
REQ-030 Press 3 cycles, then 4 presses of 10 cycles, gaps of 5 cycles -> user_input=1, load one cycle at fall+2, symbol_count returns to 0.
REQ-031 Five 3-cycle presses -> user_input=5 with load. Press of exactly 8 cycles counts as a dash, 7 cycles as a dot (boundary check).
REQ-032 Pattern 10101 -> invalid for one cycle, no load, user_input unchanged.
REQ-033 Two symbols, then 25 idle cycles -> invalid at gap cycle 20, busy falls, symbol_count=0.
REQ-034 enable dropped after 3 symbols, then restored, then the full digit 9 entered -> only load with user_input=9, no stray strobe.
REQ-035 rst asserted during the 4th press -> all outputs 0 immediately; after release, a fresh digit 0 decodes correctly.
